// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

    // Transmitter FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } tx_state_t;

    // err_code values reported with tx_err.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    // Common keyboard command bytes.
    localparam logic [7:0] CMD_SET_LED   = 8'hED;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] CMD_RESET     = 8'hFF;

    // PS/2 frames carry odd parity: the parity bit makes the count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one open-collector PS/2 line: 2-FF synchronizer, then a level
// filter that needs FILTER_LEN consecutive differing samples before the
// filtered level follows, plus a one-cycle strobe on each filtered 1->0.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          settle;

    // The idle bus is pulled high, so everything resets to 1.
    assign settle = (sync2 != level) && (cnt == CW'(FILTER_LEN - 1));

    // Two-stage synchronizer for the asynchronous line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= line_i;
            sync2 <= sync1;
        end
    end

    // Stable-sample filter and falling-edge strobe; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            fall <= settle && !sync2;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts out one command byte on device clock falling edges and checks the
// device ACK. Lines are only ever pulled low through registered output enables.
//
// Command handshake: a byte is taken on any clock edge where tx_valid and
// tx_ready are both high; tx_data must be stable in that cycle. tx_ready is
// low for the whole transfer including the done/err pulse cycle, and a
// tx_valid seen while tx_ready is low is dropped, not queued.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12_000,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    tx_state_t     state, state_nx;
    logic [7:0]    data_q, data_nx;
    logic          par_q, par_nx;
    logic [3:0]    bit_cnt, bit_nx;
    logic [IW-1:0] inh_cnt, inh_nx;
    logic [TW-1:0] tmo_cnt, tmo_nx;
    logic          clk_oe_nx, data_oe_nx;
    logic          done_nx, err_nx, ready_nx, busy_nx;
    logic [1:0]    code_nx;

    logic          clk_lvl, clk_fall;
    logic          data_lvl;
    logic          unused_data_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_clk_i),
        .level  (clk_lvl),
        .fall   (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_data_i),
        .level  (data_lvl),
        .fall   (unused_data_fall)
    );

    // State, datapath and registered outputs; reset releases both lines at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            data_q      <= '0;
            par_q       <= 1'b0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            tmo_cnt     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            err_code    <= ERR_NONE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            data_q      <= data_nx;
            par_q       <= par_nx;
            bit_cnt     <= bit_nx;
            inh_cnt     <= inh_nx;
            tmo_cnt     <= tmo_nx;
            ps2_clk_oe  <= clk_oe_nx;
            ps2_data_oe <= data_oe_nx;
            tx_done     <= done_nx;
            tx_err      <= err_nx;
            err_code    <= code_nx;
            tx_ready    <= ready_nx;
            busy        <= busy_nx;
        end
    end

    // Next-state and next-output logic. The INHIBIT state lasts
    // INHIBIT_CYCLES-1 cycles; with the single RTS cycle the clock is held
    // low for exactly INHIBIT_CYCLES cycles and the start bit appears
    // INHIBIT_CYCLES cycles after the accept cycle.
    always_comb begin
        state_nx   = state;
        data_nx    = data_q;
        par_nx     = par_q;
        bit_nx     = bit_cnt;
        inh_nx     = inh_cnt;
        tmo_nx     = tmo_cnt;
        clk_oe_nx  = ps2_clk_oe;
        data_oe_nx = ps2_data_oe;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        code_nx    = err_code;

        case (state)
            IDLE: begin
                clk_oe_nx  = 1'b0;
                data_oe_nx = 1'b0;
                if (tx_valid && tx_ready) begin
                    data_nx   = tx_data;
                    par_nx    = odd_parity(tx_data);
                    code_nx   = ERR_NONE;
                    inh_nx    = '0;
                    bit_nx    = '0;
                    clk_oe_nx = 1'b1;
                    state_nx  = INHIBIT;
                end
            end

            INHIBIT: begin
                clk_oe_nx = 1'b1;
                if (inh_cnt == IW'(INHIBIT_CYCLES - 2)) begin
                    data_oe_nx = 1'b1;
                    state_nx   = RTS;
                end else begin
                    inh_nx = inh_cnt + IW'(1);
                end
            end

            RTS: begin
                clk_oe_nx = 1'b0;
                tmo_nx    = '0;
                state_nx  = SEND;
            end

            SEND, ACK, WAIT_IDLE: begin
                if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    clk_oe_nx  = 1'b0;
                    data_oe_nx = 1'b0;
                    err_nx     = 1'b1;
                    code_nx    = ERR_TIMEOUT;
                    state_nx   = IDLE;
                end else begin
                    tmo_nx = tmo_cnt + TW'(1);
                    if (state == SEND) begin
                        if (clk_fall) begin
                            bit_nx = bit_cnt + 4'd1;
                            if (bit_cnt < 4'd8) begin
                                data_oe_nx = ~data_q[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                data_oe_nx = ~par_q;
                            end else begin
                                data_oe_nx = 1'b0;
                                state_nx   = ACK;
                            end
                        end
                    end else if (state == ACK) begin
                        if (clk_fall) begin
                            if (!data_lvl) begin
                                state_nx = WAIT_IDLE;
                            end else begin
                                clk_oe_nx  = 1'b0;
                                data_oe_nx = 1'b0;
                                err_nx     = 1'b1;
                                code_nx    = ERR_NOACK;
                                state_nx   = IDLE;
                            end
                        end
                    end else begin
                        if (clk_lvl && data_lvl) begin
                            done_nx  = 1'b1;
                            state_nx = IDLE;
                        end
                    end
                end
            end

            default: begin
                clk_oe_nx  = 1'b0;
                data_oe_nx = 1'b0;
                state_nx   = IDLE;
            end
        endcase

        ready_nx = (state_nx == IDLE) && !done_nx && !err_nx;
        busy_nx  = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH  = 200;
    localparam int TMO  = 4000;
    localparam int FL   = 8;
    localparam int HALF = 50;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] err_code;
    logic       busy;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    logic dev_clk_low;
    logic dev_data_low;

    int checks;
    int errors;
    int done_cnt;
    int err_cnt;
    int both_cnt;

    // Open-collector bus with pull-ups: low if either side pulls.
    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .err_code    (err_code),
        .busy        (busy),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Pulse monitor.
    always @(negedge clk) begin
        if (rst) begin
            if (tx_done) done_cnt++;
            if (tx_err) err_cnt++;
            if (tx_done && tx_err) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a byte for one cycle; returns at the negedge after the accept edge.
    task automatic send_cmd(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Waits for a done or error pulse, bounded.
    task automatic wait_end(output logic got_done, output logic got_err,
                            output logic oe_c, output logic oe_d, output logic [1:0] code);
        for (int n = 0; n < 2 * TMO; n++) begin
            @(negedge clk);
            if (tx_done || tx_err) break;
        end
        got_done = tx_done;
        got_err  = tx_err;
        oe_c     = ps2_clk_oe;
        oe_d     = ps2_data_oe;
        code     = err_code;
    endtask

    // Device: waits for request-to-send, clocks 11 bits, samples on rising edges.
    task automatic device_frame(input logic ack, input int glitch_at, input int abort_at,
                                output logic [9:0] bits, output logic seen);
        int n;
        bits = '0;
        n    = 0;
        while (!(ps2_clk_i === 1'b1 && ps2_data_i === 1'b0) && n < 4 * INH + 200) begin
            @(negedge clk);
            n++;
        end
        seen = (ps2_clk_i === 1'b1 && ps2_data_i === 1'b0);
        if (!seen) return;
        for (int i = 1; i <= 10; i++) begin
            if (i == glitch_at) begin
                repeat (15) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_clk_low = 1'b0;
            end
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            if (i == abort_at) begin
                repeat (20) @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
            bits[i-1]   = ps2_data_i;
            dev_clk_low = 1'b0;
        end
        repeat (HALF / 2) @(negedge clk);
        if (ack) dev_data_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    initial begin
        logic [9:0] bits;
        logic       seen;
        logic       gd, ge, oc, od;
        logic [1:0] code;
        int         hi_cnt, first_d, n;
        int         d0, e0;

        checks       = 0;
        errors       = 0;
        done_cnt     = 0;
        err_cnt      = 0;
        both_cnt     = 0;
        rst          = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_code", err_code, 2'b00);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 0xED with ACK, plus inhibit timing.
        send_cmd(8'hED);
        check("acc_ready", tx_ready, 0);
        check("acc_busy", busy, 1);
        hi_cnt  = 0;
        first_d = 0;
        fork
            begin
                for (int i = 1; i < INH + 20; i++) begin
                    if (ps2_clk_oe) hi_cnt++;
                    if (ps2_data_oe && first_d == 0) first_d = i;
                    @(negedge clk);
                end
            end
            device_frame(1'b1, 0, 0, bits, seen);
            wait_end(gd, ge, oc, od, code);
        join
        check("inh_clk_cycles", hi_cnt, INH);
        check("inh_start_bit_at", first_d, INH);
        check("ed_rts_seen", seen, 1);
        check("ed_data", bits[7:0], 8'hED);
        check("ed_parity", bits[8], 1);
        check("ed_stop", bits[9], 1);
        check("ed_done", gd, 1);
        check("ed_err", ge, 0);
        check("ed_code", code, 2'b00);
        @(negedge clk);
        check("ed_ready_after", tx_ready, 1);
        check("ed_busy_after", busy, 0);

        // 0xF3 with a clock glitch mid-SEND and a tx_valid pulse while busy.
        send_cmd(8'hF3);
        fork
            device_frame(1'b1, 4, 0, bits, seen);
            wait_end(gd, ge, oc, od, code);
            begin
                repeat (INH + 300) @(negedge clk);
                tx_valid = 1'b1;
                tx_data  = 8'hAA;
                check("busy_ready_low", tx_ready, 0);
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        check("gl_data", bits[7:0], 8'hF3);
        check("gl_parity", bits[8], 1);
        check("gl_stop", bits[9], 1);
        check("gl_done", gd, 1);
        repeat (50) @(negedge clk);
        check("busy_not_accepted_clk", ps2_clk_oe, 0);
        check("busy_not_accepted_busy", busy, 0);
        check("busy_not_accepted_ready", tx_ready, 1);

        // No ACK.
        send_cmd(8'hF4);
        fork
            device_frame(1'b0, 0, 0, bits, seen);
            wait_end(gd, ge, oc, od, code);
        join
        check("nack_err", ge, 1);
        check("nack_done", gd, 0);
        check("nack_code", code, 2'b10);
        check("nack_clk_oe", oc, 0);
        check("nack_data_oe", od, 0);
        @(negedge clk);
        check("nack_ready_after", tx_ready, 1);

        // Device never clocks: timeout counted from clock release.
        send_cmd(8'h11);
        check("accept_clears_code", err_code, 2'b00);
        n = 0;
        while (ps2_clk_oe && n < 4 * INH) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!tx_err && n < 2 * TMO) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", n, TMO);
        check("tmo_code", err_code, 2'b01);
        check("tmo_clk_oe", ps2_clk_oe, 0);
        check("tmo_data_oe", ps2_data_oe, 0);
        check("tmo_done", tx_done, 0);

        // Reset during bit 5 (bit 4 of 0x0F is 0, so data is pulled low).
        send_cmd(8'h0F);
        device_frame(1'b1, 0, 5, bits, seen);
        d0 = done_cnt;
        e0 = err_cnt;
        check("mid_data_oe_before", ps2_data_oe, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_clk_oe", ps2_clk_oe, 0);
        check("mid_rst_data_oe", ps2_data_oe, 0);
        check("mid_rst_ready", tx_ready, 1);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_no_err", err_cnt - e0, 0);

        // 0xFF after reset.
        send_cmd(CMD_RESET_BYTE());
        fork
            device_frame(1'b1, 0, 0, bits, seen);
            wait_end(gd, ge, oc, od, code);
        join
        check("ff_data", bits[7:0], 8'hFF);
        check("ff_parity", bits[8], 1);
        check("ff_done", gd, 1);
        check("ff_code", code, 2'b00);

        repeat (20) @(negedge clk);
        check("total_done", done_cnt, 3);
        check("total_err", err_cnt, 2);
        check("never_both", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [7:0] CMD_RESET_BYTE();
        return 8'hFF;
    endfunction

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the sending end of the PS/2 link whose receive path is the existing keyboard decoder.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF3 typematic, 0xFF reset).
- Drives the open-collector PS2_CLK/PS2_DATA lines via output-enables; the top level builds the tristates.
- Exposes a valid/ready command interface plus done/error pulses; runs on the 100 MHz system clock.

Parameters:
- INHIBIT_CYCLES, 12_000, cycles clock is held low before request-to-send (120 us).
- TIMEOUT_CYCLES, 2_000_000, max cycles from clock release to ACK completion (20 ms).
- FILTER_LEN, 8, consecutive equal synchronized samples needed to accept a PS/2 clock/data level change.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- tx_valid  in  1  command byte available.
- tx_data  in  8  command byte.
- tx_ready  out  1  block idle, can accept a byte.
- tx_done  out  1  one-cycle pulse: byte sent and ACKed.
- tx_err  out  1  one-cycle pulse: transfer failed.
- err_code  out  2  01 timeout, 10 no ACK; holds until next accept.
- busy  out  1  transfer in progress; the receive path ignores frames while high.
- ps2_clk_i  in  1  PS2_CLK line level.
- ps2_data_i  in  1  PS2_DATA line level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release.
- ps2_data_oe  out  1  1 = pull PS2_DATA low, 0 = release.

Behaviour:
- Reset (rst=0, async): state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, tx_done=0, tx_err=0, err_code=00, counters 0. Lines release immediately, including mid-frame.
- Input conditioning: 2-FF synchronizer on each line, then a FILTER_LEN-sample stable filter. A falling edge is a filtered clock 1->0 transition, one-cycle strobe.
- Accept: on tx_valid && tx_ready, latch tx_data and compute parity = ~^tx_data (odd parity). Then go to INHIBIT, tx_ready=0, busy=1, clear err_code. tx_valid while busy is ignored; no queueing.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. Then go to RTS.
- RTS: in the first cycle, ps2_data_oe=1 (start bit) while ps2_clk_oe stays 1. Next cycle, ps2_clk_oe=0 and the timeout counter starts. Go to SEND.
- SEND: count filtered falling edges n=1..10.
  - n=1..8: ps2_data_oe = ~data[n-1] (LSB first).
  - n=9: ps2_data_oe = ~parity.
  - n=10: ps2_data_oe=0 (stop bit, line released).
  - Data changes in the cycle after the edge strobe. Go to ACK.
- ACK: on the 11th falling edge sample filtered data. 0 -> WAIT_IDLE. 1 -> error no-ACK (10).
- WAIT_IDLE: wait until filtered clock=1 and data=1, then pulse tx_done and return to IDLE.
- Timeout: counter runs RTS-release through WAIT_IDLE. On reaching TIMEOUT_CYCLES in any of those states: release both lines the same cycle, err_code=01, pulse tx_err, go to IDLE.
- No-ACK error: release lines, err_code=10, pulse tx_err, go to IDLE.
- tx_done and tx_err are never asserted together. tx_ready returns to 1 the cycle after the pulse.
- busy=1 from accept until the cycle the block returns to IDLE.
- The block never drives a line high. Both oe outputs are registered (glitch-free).

Decomposition:
- Package ps2_pkg holds:
  - state enum: IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE;
  - ERR_NONE/ERR_TIMEOUT/ERR_NOACK constants;
  - common command bytes CMD_SET_LED=8'hED, CMD_RESET=8'hFF.
- One sub-module, ps2_line_filter (synchronizer + stable filter + fall-edge strobe), instantiated once per line.

Test Plan:
- Send 0xED with the device model clocking at 12.5 kHz and ACKing:
  - data bits 1,0,1,1,0,1,1,1, parity 1, stop released;
  - tx_done pulses once; err_code=00.
- Inhibit timing: ps2_clk_oe high for exactly 12_000 cycles; ps2_data_oe rises 12_000 cycles after the accept cycle.
- Device leaves data high on the 11th edge: tx_err pulse, err_code=10, both oe=0, tx_ready=1.
- Device never clocks: tx_err at 2_000_000 cycles after clock release, err_code=01.
- Reset asserted at bit 5: both oe=0 in the same cycle, no done/err pulse. A new send of 0xFF completes: parity 1, tx_done.
- Robustness:
  - 3-cycle low glitch on ps2_clk_i mid-SEND is ignored (bit count unchanged);
  - tx_valid pulsed while busy is not accepted.
